wb_interconnect: RTL and testbench
==================================

// Module: wb_interconnect
// PURPOSE
//  Parametrised single-master Wishbone classic interconnect between the core and NUM_SLAVES peripherals.
//  Routes each request to one slave using base/mask decode and registers the slave-side request.
//  Returns exactly one ACK or ERR per request; unmapped addresses and unresponsive slaves raise ERR.
//  Replaces ad-hoc address-bit decode, ACK-OR and data mux at SoC top level.
// PARAMETERS
//  NUM_SLAVES     7             number of slave ports (1..16)
//  ADDR_W         32            address width
//  DATA_W         32            data width
//  SLAVE_BASE     see map       packed NUM_SLAVES*ADDR_W; slave k base at [k*ADDR_W +: ADDR_W]
//  SLAVE_MASK     see map       packed NUM_SLAVES*ADDR_W; slave k matches iff (adr & mask_k) == base_k
//  TIMEOUT_CYCLES 255           max BUSY cycles waiting for slave ACK before ERR (1..2^TIMEOUT_W-1)
//  TIMEOUT_W      8             timeout counter width
//  Default map (mask = base, one-hot): 0x80000000, 0x40000000, 0x20000000, 0x10000000, 0x08000000, 0x04000000, 0x02000000 for slaves 0..6.
// PORTS
//  clk        in   1                   clock; all logic on rising edge
//  rst        in   1                   asynchronous reset, active-low
//  m_adr_i    in   ADDR_W              master address
//  m_dat_i    in   DATA_W              master write data
//  m_sel_i    in   DATA_W/8            master byte select
//  m_we_i     in   1                   master write enable
//  m_cyc_i    in   1                   master cycle
//  m_stb_i    in   1                   master strobe
//  m_dat_o    out  DATA_W              read data to master
//  m_ack_o    out  1                   transfer complete
//  m_err_o    out  1                   transfer failed (decode miss or timeout)
//  s_adr_o    out  ADDR_W              shared slave address (registered)
//  s_dat_o    out  DATA_W              shared slave write data (registered)
//  s_sel_o    out  DATA_W/8            shared slave byte select (registered)
//  s_we_o     out  1                   shared slave write enable (registered)
//  s_cyc_o    out  NUM_SLAVES          per-slave cycle, at most one bit set
//  s_stb_o    out  NUM_SLAVES          per-slave strobe, equal to s_cyc_o
//  s_dat_i    in   NUM_SLAVES*DATA_W   slave read data, slave k at [k*DATA_W +: DATA_W]
//  s_ack_i    in   NUM_SLAVES          per-slave acknowledge
//  err_adr_o  out  ADDR_W              only with WB_IC_ERR_CAPTURE_EN: address of last ERR
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0, FSM=IDLE, counter=0, selected index=0.
//  Decode: lowest-index matching slave wins; no match = miss.
//  FSM states: IDLE, BUSY, RESP.
//  IDLE:
//   - If m_cyc_i & m_stb_i and hit k: register adr/dat/sel/we, set s_cyc_o[k]=s_stb_o[k]=1, clear counter, go BUSY.
//   - If miss: go RESP with m_err_o=1, m_dat_o=0.
//  BUSY:
//   - Sample s_ack_i[k] only; ACKs from other slaves are ignored.
//   - On ack: m_dat_o<=s_dat_i[k] (0 on write), clear s_cyc_o/s_stb_o, go RESP with m_ack_o=1.
//   - Else counter++; when counter==TIMEOUT_CYCLES: clear strobes, go RESP with m_err_o=1, m_dat_o=0.
//   - If m_cyc_i drops (abort): clear strobes, go IDLE; no ACK or ERR.
//  RESP:
//   - m_ack_o or m_err_o high for exactly one cycle (never both); m_dat_o held that cycle.
//   - Then go IDLE; m_ack_o/m_err_o return to 0 and m_dat_o is cleared.
//   - A request present in the IDLE cycle after RESP is treated as new.
//  Latency: slave acking immediately -> m_ack_o 2 cycles after request sampled; miss -> m_err_o 1 cycle after.
//  Ack and timeout in the same cycle: ack wins.
//  Strobes are one-hot or zero at all times.
// CONFIGURATION
//  WB_IC_ERR_CAPTURE_EN defined:
//   - err_adr_o loads the registered/decoded request address on every ERR entry (miss or timeout).
//   - Holds until the next ERR; reset value 0.
//  Undefined: err_adr_o port absent; all other behaviour identical.
// TESTING
//  Read 0x40000010, slave1 acks in 1st BUSY cycle with 0xDEADBEEF -> s_stb_o=7'b0000010 for 1 cycle; m_ack_o pulse, m_dat_o=0xDEADBEEF.
//  Write 0x20000004 data 0x55, sel 4'b0001 -> s_dat_o=0x55, s_we_o=1 on slave2; m_ack_o after ack; m_err_o stays 0.
//  Access 0x00001000 (miss) -> no s_stb_o bit set; m_err_o pulses 1 cycle after request; m_dat_o=0; err_adr_o=0x00001000 if enabled.
//  Slave 3 never acks, TIMEOUT_CYCLES=8 -> strobe held 8 cycles, then dropped; m_err_o pulse; later request to slave 0 works.
//  Slave 4 selected, slave 5 asserts ack spuriously, then slave 4 acks 0x1234 -> spurious ack ignored; m_dat_o=0x1234.
//  rst low mid-BUSY, and separately m_cyc_i dropped mid-BUSY -> strobes 0 next edge (reset immediately), FSM IDLE, no ack/err.

Source files
------------

// File: rtl/wb_interconnect.sv
// wb_interconnect
//   Single-master Wishbone classic interconnect fanning one core out to
//   NUM_SLAVES peripherals. Each request is decoded by base/mask with the
//   lowest-index match winning, and the slave-side request is registered.
//   Every request that is not aborted receives exactly one ACK or ERR. An
//   unmapped address, or a slave that stays silent for TIMEOUT_CYCLES BUSY
//   cycles, produces ERR.
//
// Ports
//   clk, rst              clock (rising edge); asynchronous reset, active-low
//   m_*_i / m_*_o         master side: adr, dat, sel, we, cyc, stb in; dat, ack, err out
//   s_adr_o..s_we_o       shared registered slave request
//   s_cyc_o / s_stb_o     per-slave cycle/strobe, one-hot or zero
//   s_dat_i / s_ack_i     per-slave read data (slave k at [k*DATA_W +: DATA_W]) and ack
//   err_adr_o             address of the last ERR (only with WB_IC_ERR_CAPTURE_EN)
//
// Build option
//   WB_IC_ERR_CAPTURE_EN  adds err_adr_o; all other behaviour is unchanged
module wb_interconnect #(
  parameter int unsigned NUM_SLAVES     = 7,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {
    32'h0200_0000, 32'h0400_0000, 32'h0800_0000, 32'h1000_0000,
    32'h2000_0000, 32'h4000_0000, 32'h8000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {
    32'h0200_0000, 32'h0400_0000, 32'h0800_0000, 32'h1000_0000,
    32'h2000_0000, 32'h4000_0000, 32'h8000_0000},
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            m_adr_i,
  input  logic [DATA_W-1:0]            m_dat_i,
  input  logic [DATA_W/8-1:0]          m_sel_i,
  input  logic                         m_we_i,
  input  logic                         m_cyc_i,
  input  logic                         m_stb_i,
  output logic [DATA_W-1:0]            m_dat_o,
  output logic                         m_ack_o,
  output logic                         m_err_o,
  output logic [ADDR_W-1:0]            s_adr_o,
  output logic [DATA_W-1:0]            s_dat_o,
  output logic [DATA_W/8-1:0]          s_sel_o,
  output logic                         s_we_o,
  output logic [NUM_SLAVES-1:0]        s_cyc_o,
  output logic [NUM_SLAVES-1:0]        s_stb_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]        s_ack_i
`ifdef WB_IC_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0]            err_adr_o
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t                 state, state_nxt;
  logic [TIMEOUT_W-1:0]   cnt;
  logic [TIMEOUT_W-1:0]   cnt_nxt;
  logic [NUM_SLAVES-1:0]  hit_vec;
  logic                   hit;
  logic                   req;
  logic                   ack_sel;
  logic [DATA_W-1:0]      ack_dat;
  logic                   timeout;
  logic                   take_req, miss, done_ack, done_to, abort;

  assign s_stb_o = s_cyc_o;
  assign req     = m_cyc_i & m_stb_i;
  assign cnt_nxt = cnt + TIMEOUT_W'(1);
  // cnt counts completed BUSY cycles, so the incremented value reaching the
  // limit means this is the TIMEOUT_CYCLES-th cycle the strobe has been held.
  assign timeout = (cnt_nxt == TIMEOUT_W'(TIMEOUT_CYCLES));

  // Priority decode: the first match in index order claims the request.
  always_comb begin
    hit_vec = '0;
    hit     = 1'b0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (!hit && ((m_adr_i & SLAVE_MASK[k*ADDR_W +: ADDR_W]) ==
                   SLAVE_BASE[k*ADDR_W +: ADDR_W])) begin
        hit_vec[k] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  // s_cyc_o is the one-hot record of the selected slave, so gating with it
  // ignores acks and data from every other port.
  always_comb begin
    ack_sel = |(s_ack_i & s_cyc_o);
    ack_dat = '0;
    for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
      if (s_cyc_o[k]) ack_dat = ack_dat | s_dat_i[k*DATA_W +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; an abort takes precedence, then ack over timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = hit ? ST_BUSY : ST_RESP;
      ST_BUSY: begin
        if (!m_cyc_i)               state_nxt = ST_IDLE;
        else if (ack_sel || timeout) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output-event decode feeding the registered outputs
  always_comb begin
    take_req = (state == ST_IDLE) &&  req &&  hit;
    miss     = (state == ST_IDLE) &&  req && !hit;
    abort    = (state == ST_BUSY) && !m_cyc_i;
    done_ack = (state == ST_BUSY) &&  m_cyc_i &&  ack_sel;
    done_to  = (state == ST_BUSY) &&  m_cyc_i && !ack_sel && timeout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_dat_o <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_sel_o <= '0;
      s_we_o  <= 1'b0;
      s_cyc_o <= '0;
      cnt     <= '0;
    end else begin
      // Response flags and data live for the RESP cycle only.
      m_ack_o <= done_ack;
      m_err_o <= miss || done_to;
      m_dat_o <= (done_ack && !s_we_o) ? ack_dat : '0;
      if (take_req) begin
        s_adr_o <= m_adr_i;
        s_dat_o <= m_dat_i;
        s_sel_o <= m_sel_i;
        s_we_o  <= m_we_i;
        s_cyc_o <= hit_vec;
        cnt     <= '0;
      end else if (state == ST_BUSY) begin
        if (done_ack || done_to || abort) s_cyc_o <= '0;
        else                              cnt     <= cnt_nxt;
      end
    end
  end

`ifdef WB_IC_ERR_CAPTURE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         err_adr_o <= '0;
    else if (miss)    err_adr_o <= m_adr_i;
    else if (done_to) err_adr_o <= s_adr_o;
  end
`endif

endmodule

// File: tb/tb_wb_interconnect.sv
module tb_wb_interconnect;

  localparam int NS = 7;
  localparam int AW = 32;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    m_adr_i;
  logic [DW-1:0]    m_dat_i;
  logic [DW/8-1:0]  m_sel_i;
  logic             m_we_i, m_cyc_i, m_stb_i;
  logic [DW-1:0]    m_dat_o;
  logic             m_ack_o, m_err_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [DW/8-1:0]  s_sel_o;
  logic             s_we_o;
  logic [NS-1:0]    s_cyc_o, s_stb_o;
  logic [NS*DW-1:0] s_dat_i;
  logic [NS-1:0]    s_ack_i;
`ifdef WB_IC_ERR_CAPTURE_EN
  logic [AW-1:0]    err_adr_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_interconnect #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .TIMEOUT_CYCLES(8), .TIMEOUT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
`ifdef WB_IC_ERR_CAPTURE_EN
    , .err_adr_o(err_adr_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [DW/8-1:0] sel, input logic we);
    m_adr_i = adr; m_dat_i = dat; m_sel_i = sel; m_we_i = we;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
  endtask

  task automatic release_master();
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
  endtask

  task automatic slave_ack(input int k, input logic [DW-1:0] dat);
    s_ack_i = '0;
    s_ack_i[k] = 1'b1;
    s_dat_i[k*DW +: DW] = dat;
  endtask

  int held;

  initial begin
    rst = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = 1'b0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = '0;
    #12;
    check("rst_stb", 64'(s_stb_o), 64'h0);
    check("rst_ack_err", {62'h0, m_ack_o, m_err_o}, 64'h0);
    check("rst_mdat", 64'(m_dat_o), 64'h0);
    check("rst_sadr", 64'(s_adr_o), 64'h0);
`ifdef WB_IC_ERR_CAPTURE_EN
    check("rst_erradr", 64'(err_adr_o), 64'h0);
`endif
    @(posedge clk); #1; rst = 1'b1;

    // Read from slave 1, acked in the first BUSY cycle
    request(32'h4000_0010, '0, 4'hF, 1'b0);
    tick();
    check("rd_stb", 64'(s_stb_o), 64'h02);
    check("rd_cyc", 64'(s_cyc_o), 64'h02);
    check("rd_sadr", 64'(s_adr_o), 64'h4000_0010);
    check("rd_noack_yet", 64'(m_ack_o), 64'h0);
    slave_ack(1, 32'hDEAD_BEEF);
    tick();
    s_ack_i = '0; release_master();
    check("rd_ack", {62'h0, m_ack_o, m_err_o}, 64'h2);
    check("rd_mdat", 64'(m_dat_o), 64'hDEAD_BEEF);
    check("rd_stb_clr", 64'(s_stb_o), 64'h0);
    tick();
    check("rd_resp_end", {62'h0, m_ack_o, m_err_o}, 64'h0);
    check("rd_mdat_clr", 64'(m_dat_o), 64'h0);

    // Write to slave 2; the slave's read bus is ignored on a write
    request(32'h2000_0004, 32'h55, 4'b0001, 1'b1);
    tick();
    check("wr_stb", 64'(s_stb_o), 64'h04);
    check("wr_sdat", 64'(s_dat_o), 64'h55);
    check("wr_we_sel", {59'h0, s_we_o, s_sel_o}, {59'h0, 1'b1, 4'b0001});
    slave_ack(2, 32'hFFFF_FFFF);
    tick();
    s_ack_i = '0; release_master();
    check("wr_ack", {62'h0, m_ack_o, m_err_o}, 64'h2);
    check("wr_mdat", 64'(m_dat_o), 64'h0);
    tick();

    // Unmapped address
    request(32'h0000_1000, 32'h77, 4'hF, 1'b0);
    tick();
    release_master();
    check("miss_stb", 64'(s_stb_o), 64'h0);
    check("miss_err", {62'h0, m_ack_o, m_err_o}, 64'h1);
    check("miss_mdat", 64'(m_dat_o), 64'h0);
`ifdef WB_IC_ERR_CAPTURE_EN
    check("miss_erradr", 64'(err_adr_o), 64'h0000_1000);
`endif
    tick();
    check("miss_err_end", 64'(m_err_o), 64'h0);

    // Slave 3 never answers: strobe held for 8 cycles, then ERR
    request(32'h1000_0000, '0, 4'hF, 1'b0);
    tick();
    check("to_stb", 64'(s_stb_o), 64'h08);
    held = 0;
    for (int i = 0; i < 20 && s_stb_o != '0; i++) begin
      held++;
      if (m_err_o) break;
      tick();
    end
    release_master();
    check("to_held", 64'(held), 64'd8);
    check("to_err", {62'h0, m_ack_o, m_err_o}, 64'h1);
    check("to_stb_clr", 64'(s_stb_o), 64'h0);
`ifdef WB_IC_ERR_CAPTURE_EN
    check("to_erradr", 64'(err_adr_o), 64'h1000_0000);
`endif
    tick();

    // Slave 0 still usable after the timeout
    request(32'h8000_0020, '0, 4'hF, 1'b0);
    tick();
    check("s0_stb", 64'(s_stb_o), 64'h01);
    slave_ack(0, 32'hA5A5_5A5A);
    tick();
    s_ack_i = '0; release_master();
    check("s0_ack", {62'h0, m_ack_o, m_err_o}, 64'h2);
    check("s0_mdat", 64'(m_dat_o), 64'hA5A5_5A5A);
    tick();

    // Slave 4 selected; slave 5 acks spuriously first
    request(32'h0800_0000, '0, 4'hF, 1'b0);
    tick();
    check("sp_stb", 64'(s_stb_o), 64'h10);
    slave_ack(5, 32'h0000_0BAD);
    tick();
    check("sp_ignored", {62'h0, m_ack_o, m_err_o}, 64'h0);
    check("sp_stb_hold", 64'(s_stb_o), 64'h10);
    slave_ack(4, 32'h0000_1234);
    tick();
    s_ack_i = '0; release_master();
    check("sp_ack", 64'(m_ack_o), 64'h1);
    check("sp_mdat", 64'(m_dat_o), 64'h1234);
    tick();

    // Overlapping match: 0xC0000000 hits slaves 0 and 1, slave 0 wins
    request(32'hC000_0000, '0, 4'hF, 1'b0);
    tick();
    check("prio_stb", 64'(s_stb_o), 64'h01);
    slave_ack(0, 32'h0000_0001);
    tick();
    s_ack_i = '0; release_master();
    check("prio_ack", 64'(m_ack_o), 64'h1);
    tick();

    // Master abort mid-BUSY
    request(32'h0400_0000, '0, 4'hF, 1'b0);
    tick();
    check("ab_stb", 64'(s_stb_o), 64'h20);
    release_master();
    tick();
    check("ab_stb_clr", 64'(s_stb_o), 64'h0);
    check("ab_noresp", {62'h0, m_ack_o, m_err_o}, 64'h0);
    tick();
    check("ab_noresp2", {62'h0, m_ack_o, m_err_o}, 64'h0);

    // Reset asserted mid-BUSY clears strobes without waiting for an edge
    request(32'h0200_0000, '0, 4'hF, 1'b0);
    tick();
    check("rb_stb", 64'(s_stb_o), 64'h40);
    #2 rst = 1'b0;
    #1;
    check("rb_stb_clr", 64'(s_stb_o), 64'h0);
    release_master();
    tick();
    rst = 1'b1;
    tick();
    check("rb_noresp", {62'h0, m_ack_o, m_err_o}, 64'h0);

    // FSM back in IDLE: a fresh request is accepted normally
    request(32'h4000_0000, '0, 4'hF, 1'b0);
    tick();
    check("rb_new_stb", 64'(s_stb_o), 64'h02);
    slave_ack(1, 32'hCAFE_F00D);
    tick();
    s_ack_i = '0; release_master();
    check("rb_new_mdat", 64'(m_dat_o), 64'hCAFE_F00D);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
